// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the binary select of a downstream N-input mux.
// The grant holds until done, withdrawal, or a hold timeout while others wait.
module rr_select_arbiter #(
    parameter int INPUTS       = 4,
    parameter int INPUTS_WIDTH = 2,
    parameter int MAX_HOLD     = 16,
    parameter int HOLD_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INPUTS-1:0]       req,
    input  logic                    done,
    output logic [INPUTS_WIDTH-1:0] select,
    output logic                    grant_valid,
    output logic [INPUTS-1:0]       grant
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_n;
    logic [INPUTS_WIDTH-1:0] last, last_n;
    logic [INPUTS_WIDTH-1:0] select_n;
    logic                    grant_valid_n;
    logic [INPUTS-1:0]       grant_n;
    logic [HOLD_WIDTH-1:0]   hold_cnt, hold_n;

    logic [INPUTS_WIDTH-1:0] ptr;
    logic [INPUTS_WIDTH:0]   idx;
    logic [INPUTS_WIDTH-1:0] winner;
    logic                    found;
    logic [INPUTS-1:0]       winner_onehot;
    logic                    timeout_hit;
    logic                    release_now;

    // Search starts after the pointer, so the pointer's own index is considered last.
    always_comb begin
        ptr    = (state == GRANT) ? select : last;
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= INPUTS; k++) begin
            idx = {1'b0, ptr} + (INPUTS_WIDTH+1)'(k);
            if (idx >= (INPUTS_WIDTH+1)'(INPUTS))
                idx = idx - (INPUTS_WIDTH+1)'(INPUTS);
            if (!found && req[idx[INPUTS_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = idx[INPUTS_WIDTH-1:0];
            end
        end
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    always_comb begin
        timeout_hit = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1)
                      && (|(req & ~grant));
        release_now = done || !req[select] || timeout_hit;
    end

    always_comb begin
        state_n       = state;
        last_n        = last;
        select_n      = select;
        grant_valid_n = grant_valid;
        grant_n       = grant;
        hold_n        = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = GRANT;
                    select_n      = winner;
                    grant_valid_n = 1'b1;
                    grant_n       = winner_onehot;
                    hold_n        = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_n = select;
                    hold_n = '0;
                    if (found) begin
                        select_n      = winner;
                        grant_valid_n = 1'b1;
                        grant_n       = winner_onehot;
                    end else begin
                        state_n       = IDLE;
                        grant_valid_n = 1'b0;
                        grant_n       = '0;
                    end
                end else if (int'(hold_cnt) < MAX_HOLD) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= INPUTS_WIDTH'(INPUTS - 1);
            select      <= '0;
            grant_valid <= 1'b0;
            grant       <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            select      <= select_n;
            grant_valid <= grant_valid_n;
            grant       <= grant_n;
            hold_cnt    <= hold_n;
        end
    end

endmodule
